// File: rtl/l0_pkg.sv
// Shared constants and FSM state type for the L0 activation loader.
package l0_pkg;

  localparam int ROW    = 8;
  localparam int BW     = 4;
  localparam int ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/l0_skid2.sv
// Two-entry skid buffer: slot0 is always the head, slot1 holds the second word.
module l0_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= data;
          else               slot1 <= data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            slot0 <= data;
          end else begin
            slot0 <= slot1;
            slot1 <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign empty = (count == 2'd0);

endmodule

// File: rtl/l0_loader.sv
// Streams len words from the activation SRAM into L0 through a 2-entry skid buffer.
// Optional stall counter enabled by defining L0_LOADER_PERF_EN.
module l0_loader #(
  parameter int row    = l0_pkg::ROW,
  parameter int bw     = l0_pkg::BW,
  parameter int ADDR_W = l0_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [row*bw-1:0] sram_q,
  input  logic              l0_ready,
  output logic              l0_wr,
  output logic [row*bw-1:0] l0_in,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt,
  output logic [1:0]        dbg_state
);
  import l0_pkg::*;

  localparam int W = row * bw;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              pop;
  logic              issue;
  logic              sk_empty;
  logic [1:0]        sk_count;
  logic [W-1:0]      sk_head;
  logic [2:0]        occ_after_pop;

  // Only issue when the returning word is guaranteed a free skid slot.
  assign pop           = !sk_empty && l0_ready;
  assign occ_after_pop = {1'b0, sk_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = (state == FETCH) && (remaining != '0) && (occ_after_pop < 3'd2);

  l0_skid2 #(.W(W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .pop   (pop),
    .data  (sram_q),
    .head  (sk_head),
    .empty (sk_empty),
    .count (sk_count)
  );

  assign sram_cen  = !issue;
  assign sram_wen  = 1'b1;
  assign sram_addr = issue ? next_addr : last_addr;
  assign l0_wr     = pop;
  assign l0_in     = sk_head;
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      next_addr <= '0;
      last_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        next_addr <= next_addr + ADDR_ONE;
        last_addr <= next_addr;
        remaining <= remaining - LEN_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            next_addr <= base_addr;
            remaining <= len;
            state     <= (len == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (issue && (remaining == LEN_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          // Finish once the skid empties this cycle and nothing is still returning.
          if (!inflight && (sk_count == (pop ? 2'd1 : 2'd0))) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L0_LOADER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else if ((state == IDLE) && start) begin
      stall_q <= 16'd0;
    end else if (!sk_empty && !l0_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_l0_loader.sv
// Randomized bench for l0_loader: SRAM model, address-ordered expected queue, cycle rules model.
module tb_l0_loader;

  localparam int AW = 11;
  localparam int W  = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_q;
  logic          l0_ready;
  logic          l0_wr;
  logic [W-1:0]  l0_in;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;
  logic [1:0]    dbg_state;

  logic [W-1:0]  mem [0:2047];
  logic [W-1:0]  exp_q[$];
  int            n_chk;
  int            n_err;

  l0_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_addr (sram_addr),
    .sram_q    (sram_q),
    .l0_ready  (l0_ready),
    .l0_wr     (l0_wr),
    .l0_in     (l0_in),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    if (!sram_cen) sram_q <= mem[sram_addr];
    else           sram_q <= $urandom();
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_cen", 32'(sram_cen), 1);
    chk("rst_wen", 32'(sram_wen), 1);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_wr", 32'(l0_wr), 0);
    chk("rst_in", l0_in, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_state", 32'(dbg_state), 0);
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low in cycles 4..7 after start
  task automatic run_xfer(input logic [AW-1:0] b, input int n, input int mode,
                          input bit restart, input bit abort);
    int issued, wr_total, iss_km1, iss_km2, last_wr_c, third_c, exp_stall, occ, infl;
    bit exp_iss, exp_wr, exp_done, fin;
    logic [W-1:0] w;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i) % 2048]);
    issued = 0; wr_total = 0; iss_km1 = 0; iss_km2 = 0;
    last_wr_c = -10; third_c = -10; exp_stall = 0; fin = 1'b0;
    for (int c = 0; c < 4 * n + 60 && !fin; c++) begin
      @(negedge clk);
      start = (c == 0) || (restart && c == 3);
      if (c == 0) begin
        base_addr = b;
        len       = 12'(n);
      end else begin
        base_addr = AW'($urandom());
        len       = 12'($urandom_range(0, 4095));
      end
      case (mode)
        0:       l0_ready = 1'b1;
        1:       l0_ready = ($urandom_range(0, 2) != 0);
        default: l0_ready = !(c >= 4 && c <= 7);
      endcase
      if (abort && c == third_c + 1) reset = 1'b1;
      #1;
      occ      = iss_km2 - wr_total;
      infl     = iss_km1 - iss_km2;
      exp_wr   = (occ > 0) && l0_ready;
      exp_iss  = (c >= 1) && (issued < n) && ((occ + infl - int'(exp_wr)) < 2);
      exp_done = (n == 0) ? (c == 1) : (wr_total == n && last_wr_c == c - 1);
      chk("l0_wr", 32'(l0_wr), 32'(exp_wr));
      chk("cen", 32'(sram_cen), 32'(!exp_iss));
      chk("wen", 32'(sram_wen), 1);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'((c >= 1) && !exp_done));
      if (exp_wr) begin
        if (exp_q.size() == 0) chk("q_under", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("l0_in", l0_in, w);
        end
      end
      if (exp_iss) chk("addr", 32'(sram_addr), 32'((int'(b) + issued) % 2048));
      if (c == 1) chk("stall_clr", 32'(stall_cnt), 0);
      if (exp_done) begin
        chk("n_wr", 32'(wr_total), 32'(n));
        chk("q_left", 32'(exp_q.size()), 0);
`ifdef L0_LOADER_PERF_EN
        chk("stall", 32'(stall_cnt), 32'(exp_stall));
`else
        chk("stall", 32'(stall_cnt), 0);
`endif
        fin = 1'b1;
      end
      if (occ > 0 && !l0_ready) exp_stall++;
      if (exp_iss) begin
        issued++;
        if (issued == 3) third_c = c;
      end
      if (exp_wr) begin
        wr_total++;
        last_wr_c = c;
      end
      iss_km2 = iss_km1;
      iss_km1 = issued;
      if (reset) fin = 1'b1;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; l0_ready = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_values();
    @(negedge clk);
    reset = 1'b0;

    run_xfer(11'h010, 4, 0, 1'b0, 1'b0);
    run_xfer(AW'($urandom()), 8, 2, 1'b0, 1'b0);
`ifdef L0_LOADER_PERF_EN
    chk("stall_win", 32'(stall_cnt), 4);
`else
    chk("stall_win", 32'(stall_cnt), 0);
`endif
    run_xfer(11'h123, 0, 0, 1'b0, 1'b0);
    run_xfer(11'h7FE, 4, 0, 1'b0, 1'b0);
    run_xfer(AW'($urandom()), 10, 1, 1'b1, 1'b0);

    run_xfer(AW'($urandom()), 16, 0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; l0_ready = 1'b1;
    #1;
    chk_reset_values();
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("ab_wr", 32'(l0_wr), 0);
      chk("ab_done", 32'(done), 0);
      chk("ab_cen", 32'(sram_cen), 1);
      chk("ab_in", l0_in, 0);
    end
    run_xfer(AW'($urandom()), 2, 1, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++)
      run_xfer(AW'($urandom()), $urandom_range(1, 40), 1, (k % 3) == 0, 1'b0);
    run_xfer(AW'($urandom()), 2048, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
